// File: rtl/vga_frame_scheduler.sv
// VGA raster sequencer and game-tick scheduler; x/y/sync/de registered together (one clk after pix_stb).
// No backpressure on the raster; tick_req holds until tick_ack, a tick due while still pending sets overrun.
module vga_frame_scheduler #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_stb,
    input  logic [3:0] tick_div,
    input  logic       pause,
    input  logic       tick_ack,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_end,
    output logic       tick_req,
    output logic       overrun
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] X_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] Y_VIS    = 10'(V_ACTIVE);

    logic [9:0] x_nxt, y_nxt;
    logic       frame_wrap;
    logic [3:0] frame_cnt;
    logic [3:0] div_eff;
    logic [4:0] cnt_inc;
    logic       tick_due;

    // Decode is done on the next position so sync/de land on the same edge as x/y.
    always_comb begin
        x_nxt      = x;
        y_nxt      = y;
        frame_wrap = 1'b0;
        if (pix_stb) begin
            if (x == X_LAST) begin
                x_nxt = '0;
                if (y == Y_LAST) begin
                    y_nxt      = '0;
                    frame_wrap = 1'b1;
                end else begin
                    y_nxt = y + 10'd1;
                end
            end else begin
                x_nxt = x + 10'd1;
            end
        end
    end

    always_comb begin
        div_eff  = (tick_div == 4'd0) ? 4'd1 : tick_div;
        cnt_inc  = {1'b0, frame_cnt} + 5'd1;
        tick_due = frame_end && !pause && (cnt_inc >= {1'b0, div_eff});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x         <= '0;
            y         <= '0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
            de        <= 1'b1;
            frame_end <= 1'b0;
            frame_cnt <= '0;
            tick_req  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            x         <= x_nxt;
            y         <= y_nxt;
            hsync     <= !((x_nxt >= HS_START) && (x_nxt < HS_END));
            vsync     <= !((y_nxt >= VS_START) && (y_nxt < VS_END));
            de        <= (x_nxt < X_VIS) && (y_nxt < Y_VIS);
            frame_end <= frame_wrap;

            if (pause) begin
                frame_cnt <= '0;
            end else if (frame_end) begin
                frame_cnt <= tick_due ? 4'd0 : cnt_inc[3:0];
            end

            // A new tick wins over a same-cycle ack; it only counts as overrun if unacked.
            if (tick_due) begin
                tick_req <= 1'b1;
                if (tick_req && !tick_ack) begin
                    overrun <= 1'b1;
                end
            end else if (tick_ack) begin
                tick_req <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Bench: full-size instance for line timing/hold, shrunken-raster instance for frame and tick behaviour.
module tb_vga_frame_scheduler;

    logic       clk;
    int         n_cmp = 0;
    int         n_bad = 0;

    // full-size instance
    logic       rst, stb, pause, ack;
    logic [3:0] div;
    logic       hs, vs, de, fe, req, ovr;
    logic [9:0] x, y;

    // small raster: H 8+2+3+3 = 16, V 4+2+2+2 = 10 (hsync low x 10..12, vsync low y 6..7)
    logic       rst_s, stb_s, pause_s, ack_s;
    logic [3:0] div_s;
    logic       hs_s, vs_s, de_s, fe_s, req_s, ovr_s;
    logic [9:0] xs, ys;

    vga_frame_scheduler dut (
        .clk(clk), .rst(rst), .pix_stb(stb), .tick_div(div), .pause(pause), .tick_ack(ack),
        .hsync(hs), .vsync(vs), .de(de), .x(x), .y(y),
        .frame_end(fe), .tick_req(req), .overrun(ovr)
    );

    vga_frame_scheduler #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) dut_s (
        .clk(clk), .rst(rst_s), .pix_stb(stb_s), .tick_div(div_s), .pause(pause_s), .tick_ack(ack_s),
        .hsync(hs_s), .vsync(vs_s), .de(de_s), .x(xs), .y(ys),
        .frame_end(fe_s), .tick_req(req_s), .overrun(ovr_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic strobe_big();
        stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic reset_small();
        rst_s = 1'b1;
        @(negedge clk);
        rst_s = 1'b0;
    endtask

    task automatic wait_fe_s();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fe_s && n < 400);
        chk("fe_wait", 32'(fe_s), 1);
    endtask

    task automatic wait_pos_s(input logic [9:0] px, input logic [9:0] py);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(xs == px && ys == py) && n < 400);
        chk("pos_wait", {12'd0, xs, ys}, {12'd0, px, py});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int x_bad = 0, hs_cnt = 0, hold_bad = 0;
        int fe_cnt = 0, fe_bad = 0, fe_at = 0, de_cnt = 0, vs_cnt = 0, vs_bad = 0;
        logic [9:0] hs_first = '0, de_first = '0;
        logic de_seen = 1'b0;

        clk = 0; rst = 1; stb = 0; div = 0; pause = 0; ack = 0;
        rst_s = 1; stb_s = 0; div_s = 0; pause_s = 0; ack_s = 0;
        repeat (2) @(negedge clk);

        chk("rst_x", 32'(x), 0);
        chk("rst_y", 32'(y), 0);
        chk("rst_hsync", 32'(hs), 1);
        chk("rst_vsync", 32'(vs), 1);
        chk("rst_de", 32'(de), 1);
        chk("rst_fe", 32'(fe), 0);
        chk("rst_req", 32'(req), 0);
        chk("rst_ovr", 32'(ovr), 0);
        rst = 0;
        rst_s = 0;

        // one full 800-pixel line, strobe every 4th clk
        for (int k = 1; k <= 800; k++) begin
            strobe_big();
            if (x != 10'(k % 800) || y != 10'(k / 800)) x_bad++;
            if (!hs) begin
                if (hs_cnt == 0) hs_first = x;
                hs_cnt++;
            end
            if (!de && !de_seen) begin
                de_seen  = 1'b1;
                de_first = x;
            end
        end
        chk("line_x_track", 32'(x_bad), 0);
        chk("line_wrap_x", 32'(x), 0);
        chk("line_wrap_y", 32'(y), 1);
        chk("hsync_width", 32'(hs_cnt), 96);
        chk("hsync_start", 32'(hs_first), 656);
        chk("de_low_start", 32'(de_first), 640);

        for (int k = 0; k < 300; k++) strobe_big();
        repeat (100) begin
            @(negedge clk);
            if (x != 10'd300 || y != 10'd1 || !de || !hs || !vs) hold_bad++;
        end
        chk("hold_changes", 32'(hold_bad), 0);
        chk("hold_x", 32'(x), 300);

        // small raster: one full frame with pix_stb high every clk
        reset_small();
        stb_s = 1'b1;
        for (int k = 1; k <= 170; k++) begin
            @(negedge clk);
            if (fe_s) begin
                fe_cnt++;
                fe_at = k;
                if (xs != 0 || ys != 0) fe_bad++;
            end
            if (k <= 160) begin
                if (de_s) de_cnt++;
                if (!vs_s) begin
                    vs_cnt++;
                    if (ys != 10'd6 && ys != 10'd7) vs_bad++;
                end
            end
        end
        chk("fe_count", 32'(fe_cnt), 1);
        chk("fe_cycle", 32'(fe_at), 160);
        chk("fe_at_origin", 32'(fe_bad), 0);
        chk("de_per_frame", 32'(de_cnt), 32);
        chk("vsync_low_cnt", 32'(vs_cnt), 32);
        chk("vsync_rows", 32'(vs_bad), 0);

        // tick_div=3 with prompt ack
        div_s = 4'd3;
        reset_small();
        for (int f = 1; f <= 9; f++) begin
            wait_fe_s();
            @(negedge clk);
            chk($sformatf("t3_f%0d", f), 32'(req_s), (f % 3 == 0) ? 1 : 0);
            if (req_s) begin
                ack_s = 1'b1;
                @(negedge clk);
                ack_s = 1'b0;
                chk($sformatf("t3_clr%0d", f), 32'(req_s), 0);
            end
        end
        chk("t3_ovr", 32'(ovr_s), 0);

        // tick_div=0 behaves as 1
        div_s = 4'd0;
        for (int f = 1; f <= 2; f++) begin
            wait_fe_s();
            @(negedge clk);
            chk($sformatf("t0_f%0d", f), 32'(req_s), 1);
            ack_s = 1'b1;
            @(negedge clk);
            ack_s = 1'b0;
        end

        // overrun with no ack
        div_s = 4'd1;
        reset_small();
        wait_fe_s();
        @(negedge clk);
        chk("ov_f1_req", 32'(req_s), 1);
        chk("ov_f1_ovr", 32'(ovr_s), 0);
        wait_fe_s();
        @(negedge clk);
        chk("ov_f2_ovr", 32'(ovr_s), 1);
        wait_fe_s();
        @(negedge clk);
        chk("ov_f3_ovr", 32'(ovr_s), 1);
        ack_s = 1'b1;
        @(negedge clk);
        ack_s = 1'b0;
        chk("ov_ack_req", 32'(req_s), 0);
        chk("ov_ack_ovr", 32'(ovr_s), 1);

        // pause across frames 2-5, tick_div=4
        div_s = 4'd4;
        reset_small();
        for (int f = 1; f <= 9; f++) begin
            wait_fe_s();
            @(negedge clk);
            chk($sformatf("p4_f%0d", f), 32'(req_s), (f == 9) ? 1 : 0);
            if (f == 1) pause_s = 1'b1;
            if (f == 5) pause_s = 1'b0;
        end

        // tick due in the same cycle as ack: stays pending, no overrun
        div_s = 4'd1;
        wait_fe_s();
        ack_s = 1'b1;
        @(negedge clk);
        ack_s = 1'b0;
        chk("same_req", 32'(req_s), 1);
        chk("same_ovr", 32'(ovr_s), 0);
        wait_fe_s();
        @(negedge clk);
        chk("pre_rst_ovr", 32'(ovr_s), 1);

        // reset mid-frame with a tick pending and overrun set
        wait_pos_s(10'd5, 10'd2);
        rst_s = 1'b1;
        @(negedge clk);
        chk("mrst_x", 32'(xs), 0);
        chk("mrst_y", 32'(ys), 0);
        chk("mrst_hsync", 32'(hs_s), 1);
        chk("mrst_vsync", 32'(vs_s), 1);
        chk("mrst_de", 32'(de_s), 1);
        chk("mrst_req", 32'(req_s), 0);
        chk("mrst_ovr", 32'(ovr_s), 0);
        chk("mrst_fe", 32'(fe_s), 0);
        rst_s = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
